// File: rtl/packet_dm_mem_req.sv
// rtl/packet_dm_mem_req.sv - EMIF DFH register block with memory-subsystem reset/calibration FSM
module packet_dm_mem_req #(
    parameter int          NUM_CH  = 4,
    parameter logic [11:0] FEAT_ID = 12'h009,
    parameter logic [23:0] NXT_DFH = 24'h001000,
    parameter logic        EOL     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [11:0]       req_addr,
    input  logic              req_dw64,
    input  logic [9:0]        req_tag,
    input  logic [63:0]       req_wdata,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [9:0]        cpl_tag,
    output logic [2:0]        cpl_status,
    output logic              cpl_has_data,
    output logic [63:0]       cpl_data,
    output logic              mem_ss_rst_req,
    input  logic              mem_ss_rst_ack_n,
    input  logic [NUM_CH-1:0] mem_ss_cal_success,
    input  logic [NUM_CH-1:0] mem_ss_cal_fail
);

    typedef enum logic [1:0] {RST_REQ, WAIT_CAL, READY} mem_state_t;
    typedef enum logic [1:0] {P_IDLE, P_ACC, P_RSP, P_CPL} phase_t;

    localparam logic [NUM_CH-1:0] CH_MASK = '1;
    localparam logic [2:0]        ST_SC   = 3'b000;
    localparam logic [2:0]        ST_UR   = 3'b001;

    mem_state_t        state;
    phase_t            phase;
    logic [NUM_CH-1:0] cal_ok;
    logic [NUM_CH-1:0] cal_bad;
    logic [1:0]        p_type;
    logic [11:0]       p_addr;
    logic              p_dw64;
    logic [9:0]        p_tag;
    logic              accept;
    logic              ctrl_start;
    logic              misaligned;
    logic [63:0]       dfh_v;
    logic [63:0]       cap_v;
    logic [63:0]       status_v;
    logic [63:0]       reg_v;
    logic [63:0]       rd_data;

    assign accept     = req_valid && req_ready;
    // Only the CONTROL lower dword is writable; bit0 kicks a subsystem reset.
    assign ctrl_start = accept && (req_type == 2'b01) && (req_addr == 12'h018) && req_wdata[0];

    always_comb begin
        dfh_v              = {4'h3, 19'h0, EOL, NXT_DFH, 4'h0, FEAT_ID};
        cap_v              = '0;
        cap_v[NUM_CH-1:0]  = CH_MASK;
        status_v           = '0;
        status_v[63]       = (state == READY);
        if (state != RST_REQ) begin
            status_v[NUM_CH-1:0] = cal_ok;
            status_v[NUM_CH+7:8] = cal_bad;
        end
        case (p_addr[11:3])
            9'd0:    reg_v = dfh_v;
            9'd1:    reg_v = cap_v;
            9'd2:    reg_v = status_v;
            default: reg_v = '0;
        endcase
        misaligned = p_dw64 ? (p_addr[2:0] != 3'd0) : (p_addr[1:0] != 2'd0);
        rd_data    = p_dw64 ? reg_v : {32'h0, (p_addr[2] ? reg_v[63:32] : reg_v[31:0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RST_REQ;
            mem_ss_rst_req <= 1'b1;
            cal_ok         <= '0;
            cal_bad        <= '0;
        end else begin
            cal_ok  <= mem_ss_cal_success;
            cal_bad <= mem_ss_cal_fail;
            if (ctrl_start) begin
                state          <= RST_REQ;
                mem_ss_rst_req <= 1'b1;
            end else begin
                case (state)
                    RST_REQ: if (!mem_ss_rst_ack_n) begin
                        state          <= WAIT_CAL;
                        mem_ss_rst_req <= 1'b0;
                    end
                    WAIT_CAL: if ((mem_ss_cal_success & CH_MASK) == CH_MASK) state <= READY;
                    default: ;
                endcase
            end
        end
    end

    // Request sequencer: capture, build response, present, wait for handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= P_IDLE;
            req_ready    <= 1'b0;
            cpl_valid    <= 1'b0;
            cpl_tag      <= '0;
            cpl_status   <= '0;
            cpl_has_data <= 1'b0;
            cpl_data     <= '0;
            p_type       <= '0;
            p_addr       <= '0;
            p_dw64       <= 1'b0;
            p_tag        <= '0;
        end else begin
            case (phase)
                P_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        p_type    <= req_type;
                        p_addr    <= req_addr;
                        p_dw64    <= req_dw64;
                        p_tag     <= req_tag;
                        phase     <= P_ACC;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                P_ACC: begin
                    if (p_type == 2'b00 || p_type == 2'b10) begin
                        cpl_tag      <= p_tag;
                        cpl_has_data <= (p_type == 2'b00);
                        cpl_status   <= (p_type == 2'b10 || misaligned) ? ST_UR : ST_SC;
                        cpl_data     <= (p_type == 2'b00 && !misaligned) ? rd_data : 64'h0;
                        phase        <= P_RSP;
                    end else begin
                        req_ready <= 1'b1;
                        phase     <= P_IDLE;
                    end
                end
                P_RSP: begin
                    cpl_valid <= 1'b1;
                    phase     <= P_CPL;
                end
                default: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        req_ready <= 1'b1;
                        phase     <= P_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_dm_mem_req.sv
// tb/tb_packet_dm_mem_req.sv - self-checking bench for packet_dm_mem_req against a register-map model
module tb_packet_dm_mem_req;

    localparam logic [63:0] DFH_EXP = 64'h3000_0000_1000_0009;
    localparam logic [63:0] CAP_EXP = 64'h0000_0000_0000_000F;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [11:0] req_addr;
    logic        req_dw64;
    logic [9:0]  req_tag;
    logic [63:0] req_wdata;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [9:0]  cpl_tag;
    logic [2:0]  cpl_status;
    logic        cpl_has_data;
    logic [63:0] cpl_data;
    logic        mem_ss_rst_req;
    logic        mem_ss_rst_ack_n;
    logic [3:0]  mem_ss_cal_success;
    logic [3:0]  mem_ss_cal_fail;

    int n_assert = 0;
    int n_fail   = 0;

    // Model of the subsystem: 0 = reset requested, 1 = waiting for calibration, 2 = ready
    int         m_st;
    logic [3:0] m_succ;
    logic [3:0] m_fail;

    packet_dm_mem_req dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_dw64(req_dw64), .req_tag(req_tag), .req_wdata(req_wdata),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
        .cpl_status(cpl_status), .cpl_has_data(cpl_has_data), .cpl_data(cpl_data),
        .mem_ss_rst_req(mem_ss_rst_req), .mem_ss_rst_ack_n(mem_ss_rst_ack_n),
        .mem_ss_cal_success(mem_ss_cal_success), .mem_ss_cal_fail(mem_ss_cal_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_reg(input logic [11:0] a);
        logic [63:0] s;
        s = 64'h0;
        if (m_st != 0) s = s | 64'(m_succ) | (64'(m_fail) << 8);
        if (m_st == 2) s = s | (64'h1 << 63);
        case (int'(a) / 8)
            0:       return DFH_EXP;
            1:       return CAP_EXP;
            2:       return s;
            default: return 64'h0;
        endcase
    endfunction

    task automatic do_req(input logic [1:0] t, input logic [11:0] a, input logic d64,
                          input logic [9:0] tg, input logic [63:0] wd, input int hold);
        int          n;
        logic [2:0]  e_st;
        logic        e_hd;
        logic [63:0] e_dat;
        logic [63:0] r;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_before_req", 64'(req_ready), 64'h1);
        req_valid = 1'b1; req_type = t; req_addr = a; req_dw64 = d64; req_tag = tg; req_wdata = wd;
        step();
        req_valid = 1'b0;
        if (t == 2'b01 && a == 12'h018 && wd[0]) m_st = 0;
        if (t == 2'b00 || t == 2'b10) begin
            if (t == 2'b10) begin
                e_st = 3'b001; e_hd = 1'b0; e_dat = 64'h0;
            end else if (d64 ? (a % 8 != 0) : (a % 4 != 0)) begin
                e_st = 3'b001; e_hd = 1'b1; e_dat = 64'h0;
            end else begin
                r     = model_reg(a);
                e_st  = 3'b000;
                e_hd  = 1'b1;
                e_dat = d64 ? r : ((a % 8 >= 4) ? (r >> 32) : (r & 64'hFFFF_FFFF));
            end
            chk("cpl_valid_lat0", 64'(cpl_valid), 64'h0);
            step();
            chk("cpl_valid_lat1", 64'(cpl_valid), 64'h0);
            step();
            chk("cpl_valid_lat2", 64'(cpl_valid), 64'h1);
            chk("cpl_tag", 64'(cpl_tag), 64'(tg));
            chk("cpl_status", 64'(cpl_status), 64'(e_st));
            chk("cpl_has_data", 64'(cpl_has_data), 64'(e_hd));
            chk("cpl_data", cpl_data, e_dat);
            chk("req_ready_busy", 64'(req_ready), 64'h0);
            if (hold > 0) begin
                cpl_ready = 1'b0;
                for (int k = 0; k < hold; k++) begin
                    step();
                    chk("stall_valid", 64'(cpl_valid), 64'h1);
                    chk("stall_tag", 64'(cpl_tag), 64'(tg));
                    chk("stall_status", 64'(cpl_status), 64'(e_st));
                    chk("stall_data", cpl_data, e_dat);
                    chk("stall_req_ready", 64'(req_ready), 64'h0);
                end
                cpl_ready = 1'b1;
            end
            step();
            chk("cpl_valid_after_hs", 64'(cpl_valid), 64'h0);
            chk("req_ready_after_hs", 64'(req_ready), 64'h1);
        end else begin
            chk("posted_req_ready_low", 64'(req_ready), 64'h0);
            step();
            chk("posted_no_cpl", 64'(cpl_valid), 64'h0);
            chk("posted_req_ready_back", 64'(req_ready), 64'h1);
        end
    endtask

    initial begin
        logic [1:0]  t;
        logic [11:0] a;
        logic [63:0] wd;
        rst = 1'b1; req_valid = 1'b0; req_type = '0; req_addr = '0; req_dw64 = 1'b0;
        req_tag = '0; req_wdata = '0; cpl_ready = 1'b1; mem_ss_rst_ack_n = 1'b1;
        mem_ss_cal_success = 4'h0; mem_ss_cal_fail = 4'h0;
        m_st = 0; m_succ = 4'h0; m_fail = 4'h0;

        repeat (3) step();
        chk("rst_mem_ss_rst_req", 64'(mem_ss_rst_req), 64'h1);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_cpl_valid", 64'(cpl_valid), 64'h0);
        chk("rst_cpl_data", cpl_data, 64'h0);
        chk("rst_cpl_tag", 64'(cpl_tag), 64'h0);

        rst = 1'b0;
        step();
        chk("req_ready_after_rst", 64'(req_ready), 64'h1);
        chk("rst_req_held", 64'(mem_ss_rst_req), 64'h1);
        do_req(2'b00, 12'h010, 1'b1, 10'h011, 64'h0, 0);

        mem_ss_rst_ack_n = 1'b0;
        step();
        chk("rst_req_falls", 64'(mem_ss_rst_req), 64'h0);
        m_st = 1;
        mem_ss_rst_ack_n = 1'b1;
        step();
        chk("ack_high_no_effect", 64'(mem_ss_rst_req), 64'h0);
        do_req(2'b00, 12'h010, 1'b1, 10'h012, 64'h0, 0);

        mem_ss_cal_success = 4'hF;
        m_succ = 4'hF;
        repeat (3) step();
        m_st = 2;
        do_req(2'b00, 12'h010, 1'b1, 10'h2A3, 64'h0, 0);
        do_req(2'b00, 12'h000, 1'b1, 10'h001, 64'h0, 0);
        do_req(2'b00, 12'h008, 1'b1, 10'h002, 64'h0, 0);
        do_req(2'b10, 12'h010, 1'b1, 10'h055, 64'h0, 0);
        do_req(2'b00, 12'h00C, 1'b1, 10'h003, 64'h0, 0);
        do_req(2'b00, 12'h004, 1'b0, 10'h004, 64'h0, 0);
        do_req(2'b00, 12'h002, 1'b0, 10'h005, 64'h0, 0);
        do_req(2'b00, 12'h100, 1'b1, 10'h006, 64'h0, 0);
        do_req(2'b11, 12'h018, 1'b0, 10'h007, 64'h1, 0);
        chk("drop_no_reset", 64'(mem_ss_rst_req), 64'h0);
        do_req(2'b00, 12'h008, 1'b1, 10'h3FF, 64'h0, 5);

        mem_ss_cal_fail = 4'($urandom);
        m_fail = mem_ss_cal_fail;
        repeat (2) step();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: t = 2'b00;
                3:       t = 2'b10;
                4:       t = 2'b01;
                default: t = 2'b11;
            endcase
            a  = 12'($urandom_range(0, 47));
            wd = {$urandom, $urandom} & ~64'h1;
            do_req(t, a, 1'($urandom), 10'($urandom), wd, 0);
        end
        chk("random_state_ready", 64'(mem_ss_rst_req), 64'h0);

        do_req(2'b01, 12'h018, 1'b0, 10'h008, 64'h1, 0);
        chk("ctrl_write_rst_req", 64'(mem_ss_rst_req), 64'h1);
        do_req(2'b00, 12'h010, 1'b1, 10'h009, 64'h0, 0);
        do_req(2'b00, 12'h018, 1'b0, 10'h00A, 64'h0, 0);

        mem_ss_rst_ack_n = 1'b0;
        step();
        mem_ss_rst_ack_n = 1'b1;
        m_st = 1;
        repeat (3) step();
        m_st = 2;
        do_req(2'b00, 12'h014, 1'b0, 10'h00B, 64'h0, 0);

        req_valid = 1'b1; req_type = 2'b00; req_addr = 12'h010; req_dw64 = 1'b1; req_tag = 10'h0CC;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_cpl_valid", 64'(cpl_valid), 64'h0);
        chk("midrst_req_ready", 64'(req_ready), 64'h0);
        rst = 1'b0;
        m_st = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_no_cpl", 64'(cpl_valid), 64'h0);
        end
        chk("midrst_ready_back", 64'(req_ready), 64'h1);
        chk("midrst_rst_req", 64'(mem_ss_rst_req), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
